// File: rtl/priority_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// priority_req_ctrl_pkg
// Shared FSM state type and sizing constants for the priority request block.
// Revision: 1.0
// ============================================================================
package priority_req_ctrl_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage : priority_req_ctrl_pkg
`default_nettype wire

// File: rtl/prio_pick8.sv
`default_nettype none
// ============================================================================
// prio_pick8
// Combinational highest-set-index picker over an 8-bit vector.
// Revision: 1.0
// ============================================================================
module prio_pick8
    import priority_req_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Ascending scan: the last hit is the highest index.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule : prio_pick8
`default_nettype wire

// File: rtl/priority_req_ctrl.sv
`default_nettype none
// ============================================================================
// priority_req_ctrl
// Captures request lines into a pending register and presents the highest
// enabled pending index on a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module priority_req_ctrl
    import priority_req_ctrl_pkg::*;
#(
    parameter int EDGE_MODE = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] r,
    input  logic [NUM_REQ-1:0] mask,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] pend,
    output logic               ovf,
    input  logic               clr_ovf
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NUM_REQ-1:0]  r_prev;
    logic [NUM_REQ-1:0]  r_pend;
    logic                r_ovf;

    logic [NUM_REQ-1:0]  w_cap;
    logic [NUM_REQ-1:0]  w_set;
    logic [NUM_REQ-1:0]  w_clr;
    logic                w_ovf_evt;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;

    assign w_cap = (EDGE_MODE != 0) ? (r & ~r_prev) : r;
    assign w_set = w_cap & mask;
    assign w_clr = ((r_state == ST_PRESENT) && out_ready)
                   ? (NUM_REQ'(1) << r_idx) : '0;

    // A capture landing on a bit being cleared this edge is a re-arm, not an overflow.
    assign w_ovf_evt = (EDGE_MODE != 0) && (|(w_set & r_pend & ~w_clr));

    prio_pick8 u_pick (
        .i_req (r_pend & mask),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_idx_nxt   = w_pick_idx;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_prev  <= r;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            r_ovf   <= w_ovf_evt | (r_ovf & ~clr_ovf);
        end
    end

    assign out_idx   = r_idx;
    assign out_valid = (r_state == ST_PRESENT);
    assign pend      = r_pend;
    assign ovf       = r_ovf;

endmodule : priority_req_ctrl
`default_nettype wire

// File: tb/tb_priority_req_ctrl.sv
`default_nettype none
// ============================================================================
// tb_priority_req_ctrl
// Directed scoreboard bench for priority_req_ctrl (EDGE_MODE=1).
// Revision: 1.0
// ============================================================================
module tb_priority_req_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] r;
    logic [7:0] mask;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pend;
    logic       ovf;
    logic       clr_ovf;

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    priority_req_ctrl #(.EDGE_MODE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (r),
        .mask      (mask),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pend      (pend),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transfer monitor: a handshake seen at negedge completes on the next posedge.
    logic       m_prev_valid = 1'b0;
    logic       m_prev_acc   = 1'b0;
    logic [2:0] m_prev_idx   = 3'd0;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (m_prev_valid && !m_prev_acc)
                chk("idx_hold", 32'(out_idx), 32'(m_prev_idx));
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_xfer", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_xfer_idx", 32'(out_idx), 32'(sb_q.pop_front()));
                end
            end
        end
        m_prev_valid = rst_n && out_valid;
        m_prev_acc   = out_ready;
        m_prev_idx   = out_idx;
    end

    initial begin
        rst_n = 1'b0; r = 8'h00; mask = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        #3;
        chk("rst_pend",  32'(pend),      32'h00);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_idx",   32'(out_idx),   32'h0);
        chk("rst_ovf",   32'(ovf),       32'h0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // Single request
        mask = 8'hFF; r = 8'h10; sb_q.push_back(4);
        tick();
        chk("t1_pend",  32'(pend),      32'h10);
        chk("t1_valid_e1", 32'(out_valid), 32'h0);
        tick();
        chk("t1_valid_e2", 32'(out_valid), 32'h1);
        chk("t1_idx",   32'(out_idx),   32'h4);
        out_ready = 1'b1;
        tick();
        chk("t1_pend_clr", 32'(pend),   32'h00);
        chk("t1_valid_clr", 32'(out_valid), 32'h0);
        out_ready = 1'b0; r = 8'h00;
        tick();

        // Four simultaneous requests drained in priority order, one per 2 cycles
        out_ready = 1'b1; r = 8'b1001_0110;
        sb_q.push_back(7); sb_q.push_back(4); sb_q.push_back(2); sb_q.push_back(1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("t2_valid_pattern", 32'(out_valid), 32'((i % 2) == 0));
        end
        chk("t2_pend_empty", 32'(pend), 32'h00);
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        out_ready = 1'b0; r = 8'h00;
        tick();

        // Higher-priority arrival must not preempt an in-progress presentation
        r = 8'h04; sb_q.push_back(2);
        tick(2);
        chk("t3_idx2", 32'(out_idx), 32'h2);
        r = 8'h44; sb_q.push_back(6);
        tick();
        chk("t3_pend", 32'(pend), 32'h44);
        tick(2);
        chk("t3_idx_held", 32'(out_idx), 32'h2);
        chk("t3_valid_held", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        chk("t3_pend_after", 32'(pend), 32'h40);
        tick();
        chk("t3_idx6", 32'(out_idx), 32'h6);
        tick();
        chk("t3_pend_empty", 32'(pend), 32'h00);
        out_ready = 1'b0; r = 8'h00;
        tick();

        // Overflow, clear priority, and re-arm during acceptance
        r = 8'h08; sb_q.push_back(3);
        tick();
        r = 8'h00;
        tick();
        r = 8'h08;
        tick();
        chk("t4_ovf_set", 32'(ovf), 32'h1);
        chk("t4_pend", 32'(pend), 32'h08);
        r = 8'h00;
        tick();
        r = 8'h08; clr_ovf = 1'b1;
        tick();
        chk("t4_ovf_wins_clr", 32'(ovf), 32'h1);
        tick();
        chk("t4_ovf_cleared", 32'(ovf), 32'h0);
        clr_ovf = 1'b0; r = 8'h00;
        tick();
        r = 8'h08; out_ready = 1'b1;
        tick();
        chk("t4_set_wins_pend", 32'(pend), 32'h08);
        chk("t4_set_wins_ovf", 32'(ovf), 32'h0);
        sb_q.push_back(3);
        tick();
        chk("t4_repres_idx", 32'(out_idx), 32'h3);
        tick();
        chk("t4_pend_empty", 32'(pend), 32'h00);
        out_ready = 1'b0; r = 8'h00;
        tick();

        // Masked captures are discarded
        mask = 8'h0F; r = 8'hF0;
        tick();
        chk("t5_pend_masked", 32'(pend), 32'h00);
        tick();
        chk("t5_valid_masked", 32'(out_valid), 32'h0);
        mask = 8'hFF;
        tick(2);
        chk("t5_valid_unmask", 32'(out_valid), 32'h0);
        chk("t5_pend_unmask", 32'(pend), 32'h00);
        r = 8'h00;
        tick();

        // Reset mid-presentation with a line held high
        r = 8'h01; sb_q.push_back(0);
        tick(2);
        chk("t6_valid_pre", 32'(out_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_pend",  32'(pend),      32'h00);
        chk("t6_rst_idx",   32'(out_idx),   32'h0);
        sb_q.delete();
        tick();
        rst_n = 1'b1; sb_q.push_back(0);
        tick();
        chk("t6_pend_rearm", 32'(pend), 32'h01);
        tick();
        chk("t6_valid_post", 32'(out_valid), 32'h1);
        chk("t6_idx_post",   32'(out_idx),   32'h0);
        out_ready = 1'b1;
        tick();
        chk("t6_pend_empty", 32'(pend), 32'h00);
        out_ready = 1'b0;
        tick(2);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_priority_req_ctrl
`default_nettype wire
